fetch_queue: RTL

- Instruction queue between the fetch stage and the decode stage.
- Buffers {pc, instruction} pairs so fetch can run ahead while decode stalls.
- Its head entry drives decode, including the immediate generator's Instr input.
- Supports valid/ready handshakes on both sides and a single-cycle flush for taken branches and jumps.

---
 rtl/fetch_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : {pc, instr} FIFO between fetch and decode with single-cycle flush.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
   parameter int              DEPTH     = 4,
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] instr_mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic w_push;
   logic w_pop;
   logic w_wr_en;

   // Ready is a pure function of occupancy: a full queue stays closed even on a pop.
   assign in_ready  = (cnt_q != C_FULL);
   assign out_valid = (cnt_q != '0);
   assign count     = cnt_q;

   assign w_push  = in_valid & in_ready;
   assign w_pop   = out_valid & out_ready;
   assign w_wr_en = rst & ~flush & w_push;

   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
   assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is never cleared; validity is tracked solely by cnt_q.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         pc_mem_q[wr_ptr_q]    <= in_pc;
         instr_mem_q[wr_ptr_q] <= in_instr;
      end
   end

endmodule
`default_nettype wire
